// File: rtl/framebuffer_ram_clr.sv
// Single-clock framebuffer RAM with independent write/read ports, a hardware
// clear/fill engine, a read-valid strobe and out-of-range address protection.
module framebuffer_ram_clr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 76800,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  generate
    if (64'(MEM_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_geometry
      $error("framebuffer_ram_clr: MEM_DEPTH does not fit in ADDR_WIDTH bits");
    end
  endgenerate

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   clr_val;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic wr_in_range;
  logic rd_in_range;
  logic clr_accept;
  logic sweeping;
  logic user_we;
  logic drop_now;

  // Write arbitration: the sweep owns the array; a write coincident with an
  // accepted clr_start is already treated as busy.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    clr_accept  = (state == IDLE) && clr_start;
    sweeping    = (state == SWEEP);
    user_we     = wr_en && wr_in_range && !sweeping && !clr_accept;
    drop_now    = wr_en && !user_we;
  end

  // Clear FSM with registered busy/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_val  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            clr_val  <= clr_value;
            cnt      <= '0;
            clr_busy <= 1'b1;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          clr_done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Array write port (no reset so the array maps onto block RAM).
  always_ff @(posedge clk) begin
    if (sweeping) begin
      mem[cnt] <= clr_val;
    end else if (user_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port and write-drop strobe; reads see pre-write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      wr_drop  <= drop_now;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: doc/framebuffer_ram_clr.md
Name: framebuffer_ram_clr

Overview:
- Parametrised single-clock framebuffer RAM with independent write and read ports.
- Adds a hardware clear/fill engine that sweeps every location with a programmable value.
- Adds a read-valid strobe and out-of-range address protection.
- Sits between the pixel writer (renderer/loader) and the video scan-out reader; default geometry is 320x240 at 8 bpp.

Parameters:
- DATA_WIDTH, 8, pixel word width in bits.
- MEM_DEPTH, 76800, number of words (320*240).
- ADDR_WIDTH, 17, address width. Must satisfy MEM_DEPTH <= 2**ADDR_WIDTH; otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  user write request.
- wr_addr  input  ADDR_WIDTH  user write address.
- wr_data  input  DATA_WIDTH  user write data.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  high for one cycle when rd_data carries the result of the previous cycle's rd_en.
- clr_start  input  1  start a fill sweep; sampled only in IDLE.
- clr_value  input  DATA_WIDTH  fill value; latched on an accepted clr_start.
- clr_busy  output  1  high while the sweep is in progress.
- clr_done  output  1  one-cycle pulse after the last location is written.
- wr_drop  output  1  one-cycle pulse when a user write is discarded (busy or out of range).

Behaviour:
- Reset (asynchronous, active-high):
  - rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, wr_drop=0.
  - FSM goes to IDLE and the sweep counter clears to 0.
  - Memory contents are not reset, so the array infers as block RAM.
  - Reset asserted mid-sweep aborts the sweep and does not pulse clr_done. Already-written locations keep the fill value; the rest keep their old data.
- Read port:
  - Latency is 1 cycle: rd_en at edge N gives rd_data and rd_valid=1 after edge N.
  - rd_valid is registered from rd_en.
  - Without rd_en, rd_data holds its value and rd_valid=0.
  - rd_addr >= MEM_DEPTH returns 0, and rd_valid still asserts.
  - Read and write to the same address in the same cycle returns the OLD data (read-before-write).
  - Reads are fully serviced during a sweep and return whatever the array holds.
- User write:
  - wr_en with wr_addr < MEM_DEPTH in IDLE writes wr_data at that edge.
  - Discarded cases, each pulsing wr_drop on the next cycle with memory unchanged:
    - wr_en while clr_busy=1.
    - wr_en with wr_addr >= MEM_DEPTH.
  - A write in the same cycle as an accepted clr_start is dropped (busy takes effect in that cycle).
- Clear FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_start=1 latches clr_value, sets the counter to 0, and goes to SWEEP. clr_busy rises after this edge.
  - SWEEP: writes the latched value to mem[counter] each cycle and increments the counter.
    - When counter==MEM_DEPTH-1 is written, go to DONE.
    - The sweep is exactly MEM_DEPTH write cycles.
    - clr_start during SWEEP is ignored; there is no restart or queueing.
  - DONE: one cycle with clr_done=1 and clr_busy=0, then IDLE. A clr_start in DONE is ignored.
  - clr_busy is high only in SWEEP.
  - The counter is ADDR_WIDTH bits and never exceeds MEM_DEPTH-1, so there is no wrap.
- All outputs are registered.

Test Plan:
- Reset then write/read: write 0xA5 at addr 0 and 0x3C at addr 76799; read both -> rd_data 0xA5 then 0x3C, each with rd_valid one cycle after rd_en.
- Read-before-write: mem[100]=0x11; same cycle wr_en(100, 0x22) and rd_en(100) -> rd_data=0x11; next read of 100 -> 0x22.
- Out of range: wr_en at addr 76800 -> wr_drop pulse, memory unchanged; rd_en at 76800 -> rd_data=0x00, rd_valid=1.
- Full clear:
  - clr_start with clr_value=0x7F -> clr_busy high for exactly 76800 cycles, then clr_done for 1 cycle.
  - Random reads at 0, 38400, 76799 afterwards -> 0x7F.
  - wr_en issued mid-sweep -> wr_drop, and the location still reads 0x7F.
- Reset mid-sweep: assert rst after 1000 sweep cycles -> clr_busy=0 immediately and no clr_done. Addr 999 reads the fill value; addr 1000 reads its prior data.
- Small-geometry regression: DATA_WIDTH=16, MEM_DEPTH=5, ADDR_WIDTH=3; clear with 0xBEEF -> exactly 5 busy cycles. Addresses 0-4 read 0xBEEF; addresses 5-7 read 0 with rd_valid=1.
